// File: rtl/msdf_pkg.sv
// Shared definitions for the MSD-first on-the-fly signed-digit converter:
// the signed-digit encoding on the write bus and the converter FSM state type.
package msdf_pkg;

   localparam int unsigned SD_WIDTH = 2;

   // Signed-digit encoding on the write bus
   localparam logic [SD_WIDTH-1:0] SD_POS  = 2'b10;   // +1
   localparam logic [SD_WIDTH-1:0] SD_NEG  = 2'b01;   // -1
   localparam logic [SD_WIDTH-1:0] SD_ZERO = 2'b00;   //  0
   localparam logic [SD_WIDTH-1:0] SD_ILL  = 2'b11;   // illegal, converted as 0

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_DISCARD = 2'd2
   } msdf_state_e;

endpackage

// File: rtl/msdf_otf_converter_if.sv
// Digit write bus plus result handshake of the on-the-fly converter.
//   i_mbus_wen/wvalid/wlast/wdata : digit stream, MSD first
//   o_res_data/o_res_digits       : two's-complement result and its digit count
//   o_res_valid/i_res_ready       : result handshake
// slave = converter side, master = producer/consumer side.
interface msdf_otf_converter_if #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned OUT_WIDTH  = MAX_DIGITS + 1
);
   localparam int unsigned CNT_WIDTH = $clog2(MAX_DIGITS + 1);

   logic                  i_mbus_wen;
   logic [DATA_WIDTH-1:0] i_mbus_wdata;
   logic                  i_mbus_wvalid;
   logic                  i_mbus_wlast;
   logic [OUT_WIDTH-1:0]  o_res_data;
   logic                  o_res_valid;
   logic                  i_res_ready;
   logic [CNT_WIDTH-1:0]  o_res_digits;

   modport slave (
      input  i_mbus_wen, i_mbus_wdata, i_mbus_wvalid, i_mbus_wlast, i_res_ready,
      output o_res_data, o_res_valid, o_res_digits
   );

   modport master (
      output i_mbus_wen, i_mbus_wdata, i_mbus_wvalid, i_mbus_wlast, i_res_ready,
      input  o_res_data, o_res_valid, o_res_digits
   );

endinterface

// File: rtl/msdf_otf_qqm.sv
// On-the-fly Q/QM conversion registers (QM = Q - 1), one digit per load.
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   i_load          : shift the digit i_digit into Q/QM
//   i_clr           : clear for a new stream (wins over i_load)
//   o_q_nxt_c       : Q including i_digit (low k bits valid after k digits)
//   o_q_neg_nxt_c   : sign of the value held by o_q_nxt_c
// Only the low k bits of Q/QM are meaningful after k digits; the sign of Q
// and QM is tracked in separate flops and updated with the same selection
// rule, so no carry-propagate adder is ever needed.
module msdf_otf_qqm
   import msdf_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_load,
   input  logic                  i_clr,
   input  logic [SD_WIDTH-1:0]   i_digit,
   output logic [MAX_DIGITS-1:0] o_q_nxt_c,
   output logic                  o_q_neg_nxt_c
);

   logic [MAX_DIGITS-1:0] q_q, q_d, qm_q, qm_d;
   logic [MAX_DIGITS-1:0] q_sh, qm_sh;
   logic                  q_neg_q, q_neg_d, qm_neg_q, qm_neg_d;
   logic                  q_neg_sh, qm_neg_sh;

   // Digit selection: append to Q or QM depending on the digit value
   always_comb begin
      q_sh      = MAX_DIGITS'({q_q, 1'b0});
      qm_sh     = MAX_DIGITS'({qm_q, 1'b1});
      q_neg_sh  = q_neg_q;
      qm_neg_sh = qm_neg_q;
      unique case (i_digit)
         SD_POS: begin
            q_sh      = MAX_DIGITS'({q_q, 1'b1});
            qm_sh     = MAX_DIGITS'({q_q, 1'b0});
            qm_neg_sh = q_neg_q;
         end
         SD_NEG: begin
            q_sh     = MAX_DIGITS'({qm_q, 1'b1});
            qm_sh    = MAX_DIGITS'({qm_q, 1'b0});
            q_neg_sh = qm_neg_q;
         end
         SD_ZERO, SD_ILL: begin
         end
      endcase
   end

   // Register update; an empty stream has Q = 0 and QM = -1 (negative)
   always_comb begin
      q_d      = q_q;
      qm_d     = qm_q;
      q_neg_d  = q_neg_q;
      qm_neg_d = qm_neg_q;
      if (i_clr) begin
         q_d      = '0;
         qm_d     = '0;
         q_neg_d  = 1'b0;
         qm_neg_d = 1'b1;
      end else if (i_load) begin
         q_d      = q_sh;
         qm_d     = qm_sh;
         q_neg_d  = q_neg_sh;
         qm_neg_d = qm_neg_sh;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         q_q      <= '0;
         qm_q     <= '0;
         q_neg_q  <= 1'b0;
         qm_neg_q <= 1'b1;
      end else begin
         q_q      <= q_d;
         qm_q     <= qm_d;
         q_neg_q  <= q_neg_d;
         qm_neg_q <= qm_neg_d;
      end
   end

   assign o_q_nxt_c     = q_sh;
   assign o_q_neg_nxt_c = q_neg_sh;

endmodule

// File: rtl/msdf_otf_converter.sv
// MSD-first signed-digit to two's-complement converter.
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   bus (slave)     : digit write bus in, result + handshake out
//   o_err_illegal   : sticky, an illegal digit was converted
//   o_err_trunc     : sticky, a stream exceeded MAX_DIGITS digits
//   o_err_overrun   : sticky, an unconsumed result was overwritten
// A result is presented one cycle after the finalizing digit, scaled by
// 2^(MAX_DIGITS-1).
module msdf_otf_converter
   import msdf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned OUT_WIDTH  = MAX_DIGITS + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   msdf_otf_converter_if.slave   bus,
   output logic                  o_err_illegal,
   output logic                  o_err_trunc,
   output logic                  o_err_overrun
);

   localparam int unsigned CNT_WIDTH = $clog2(MAX_DIGITS + 1);

   msdf_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d, count_inc;
   logic [OUT_WIDTH-1:0]  res_data_q, res_data_d, res_ext, res_c;
   logic [CNT_WIDTH-1:0]  res_digits_q, res_digits_d;
   logic                  res_valid_q, res_valid_d;
   logic                  err_ill_q, err_ill_d;
   logic                  err_trunc_q, err_trunc_d;
   logic                  err_ovr_q, err_ovr_d;

   logic [SD_WIDTH-1:0]   digit;
   logic                  accept_c, at_max_c;
   logic                  load_c, fin_c, trunc_c;
   logic [MAX_DIGITS-1:0] q_nxt;
   logic                  q_neg_nxt;

   assign accept_c  = bus.i_mbus_wen && bus.i_mbus_wvalid;
   assign digit     = SD_WIDTH'(bus.i_mbus_wdata);
   assign count_inc = CNT_WIDTH'(count_q + 1'b1);
   assign at_max_c  = (count_inc == CNT_WIDTH'(MAX_DIGITS));

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept_c) begin
               if (bus.i_mbus_wlast)  state_d = ST_IDLE;
               else if (at_max_c)     state_d = ST_DISCARD;
               else                   state_d = ST_ACCUM;
            end
         end
         ST_DISCARD: begin
            if (accept_c && bus.i_mbus_wlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: load a digit, finalize, flag a truncating finalize
   always_comb begin
      load_c  = 1'b0;
      fin_c   = 1'b0;
      trunc_c = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept_c) begin
               load_c  = 1'b1;
               fin_c   = bus.i_mbus_wlast || at_max_c;
               trunc_c = !bus.i_mbus_wlast && at_max_c;
            end
         end
         default: begin
         end
      endcase
   end

   msdf_otf_qqm #(
      .MAX_DIGITS (MAX_DIGITS)
   ) u_qqm (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_load        (load_c),
      .i_clr         (fin_c),
      .i_digit       (digit),
      .o_q_nxt_c     (q_nxt),
      .o_q_neg_nxt_c (q_neg_nxt)
   );

   // Sign-extend the k valid Q bits, then align the MSD to weight 2^0
   always_comb begin
      res_ext = {q_neg_nxt, q_nxt};
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i >= 32'(count_inc)) res_ext[i] = q_neg_nxt;
      end
      res_c = res_ext << (CNT_WIDTH'(MAX_DIGITS) - count_inc);
   end

   // Result, handshake, digit counter and sticky error next state
   always_comb begin
      res_data_d   = res_data_q;
      res_digits_d = res_digits_q;
      res_valid_d  = res_valid_q && !bus.i_res_ready;
      count_d      = count_q;
      err_ill_d    = err_ill_q || (load_c && (digit == SD_ILL));
      err_trunc_d  = err_trunc_q || trunc_c;
      err_ovr_d    = err_ovr_q || (fin_c && res_valid_q && !bus.i_res_ready);
      if (fin_c) begin
         res_data_d   = res_c;
         res_digits_d = count_inc;
         res_valid_d  = 1'b1;
         count_d      = '0;
      end else if (load_c) begin
         count_d = count_inc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         res_data_q   <= '0;
         res_digits_q <= '0;
         res_valid_q  <= 1'b0;
         count_q      <= '0;
         err_ill_q    <= 1'b0;
         err_trunc_q  <= 1'b0;
         err_ovr_q    <= 1'b0;
      end else begin
         res_data_q   <= res_data_d;
         res_digits_q <= res_digits_d;
         res_valid_q  <= res_valid_d;
         count_q      <= count_d;
         err_ill_q    <= err_ill_d;
         err_trunc_q  <= err_trunc_d;
         err_ovr_q    <= err_ovr_d;
      end
   end

   assign bus.o_res_data   = res_data_q;
   assign bus.o_res_digits = res_digits_q;
   assign bus.o_res_valid  = res_valid_q;
   assign o_err_illegal    = err_ill_q;
   assign o_err_trunc      = err_trunc_q;
   assign o_err_overrun    = err_ovr_q;

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Bench for msdf_otf_converter: directed cases with literal expectations,
// then random digit streams checked every cycle against a digit-queue model
// that evaluates each stream as a plain weighted sum.
module tb_msdf_otf_converter;

   localparam int DW   = 2;
   localparam int MAXD = 8;
   localparam int OW   = MAXD + 1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic err_ill, err_trunc, err_ovr;
   bit   chk_en = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   msdf_otf_converter_if #(.DATA_WIDTH(DW), .MAX_DIGITS(MAXD)) bus ();

   msdf_otf_converter #(
      .DATA_WIDTH (DW),
      .MAX_DIGITS (MAXD)
   ) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .bus           (bus),
      .o_err_illegal (err_ill),
      .o_err_trunc   (err_trunc),
      .o_err_overrun (err_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_q[$];
   bit          m_disc;
   bit [OW-1:0] m_data;
   int          m_ndig;
   bit          m_valid, m_ill, m_trunc, m_ovr;
   bit          m_fin;
   int          m_val, m_n;

   function automatic int dval(input logic [1:0] w);
      case (w)
         2'b10:   return 1;
         2'b01:   return -1;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         m_q.delete();
         m_disc  = 1'b0;
         m_data  = '0;
         m_ndig  = 0;
         m_valid = 1'b0;
         m_ill   = 1'b0;
         m_trunc = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         m_fin = 1'b0;
         if (bus.i_mbus_wen && bus.i_mbus_wvalid) begin
            if (m_disc) begin
               if (bus.i_mbus_wlast) m_disc = 1'b0;
            end else begin
               if (bus.i_mbus_wdata == 2'b11) m_ill = 1'b1;
               m_q.push_back(dval(bus.i_mbus_wdata));
               if (bus.i_mbus_wlast || m_q.size() == MAXD) begin
                  m_fin = 1'b1;
                  if (!bus.i_mbus_wlast) begin
                     m_disc  = 1'b1;
                     m_trunc = 1'b1;
                  end
                  m_val = 0;
                  foreach (m_q[k]) m_val += m_q[k] * (1 << (MAXD - 1 - k));
                  m_n = m_q.size();
                  m_q.delete();
               end
            end
         end
         if (m_fin) begin
            if (m_valid && !bus.i_res_ready) m_ovr = 1'b1;
            m_data  = OW'(m_val);
            m_ndig  = m_n;
            m_valid = 1'b1;
         end else if (m_valid && bus.i_res_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_valid",   32'(bus.o_res_valid),  32'(m_valid));
         chk("cyc_data",    32'(bus.o_res_data),   32'(m_data));
         chk("cyc_digits",  32'(bus.o_res_digits), 32'(m_ndig));
         chk("cyc_illegal", 32'(err_ill),          32'(m_ill));
         chk("cyc_trunc",   32'(err_trunc),        32'(m_trunc));
         chk("cyc_overrun", 32'(err_ovr),          32'(m_ovr));
      end
   end

   // ---------------- stimulus ----------------
   // Apply inputs for one clock; returns at the following negedge
   task automatic drive(input bit en, input bit vld, input logic [1:0] d, input bit last);
      bus.i_mbus_wen    = en;
      bus.i_mbus_wvalid = vld;
      bus.i_mbus_wdata  = d;
      bus.i_mbus_wlast  = last;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle();
      idle();
      rstn = 1'b1;
   endtask

   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] N = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam logic [1:0] I = 2'b11;

   initial begin
      bus.i_res_ready   = 1'b1;
      bus.i_mbus_wen    = 1'b0;
      bus.i_mbus_wvalid = 1'b0;
      bus.i_mbus_wdata  = 2'b00;
      bus.i_mbus_wlast  = 1'b0;
      @(negedge clk);
      do_reset();
      chk_en = 1'b1;

      chk("rst_data",   32'(bus.o_res_data),   32'h0);
      chk("rst_valid",  32'(bus.o_res_valid),  32'h0);
      chk("rst_digits", 32'(bus.o_res_digits), 32'h0);
      chk("rst_flags",  32'({err_ill, err_trunc, err_ovr}), 32'h0);

      // +1,0,-1,+1 -> 112 over 4 digits, valid one cycle
      drive(1, 1, P, 0); drive(1, 1, Z, 0); drive(1, 1, N, 0); drive(1, 1, P, 1);
      chk("t1_data",   32'(bus.o_res_data),   32'h070);
      chk("t1_model",  32'(m_data),           32'h070);
      chk("t1_digits", 32'(bus.o_res_digits), 32'd4);
      chk("t1_valid",  32'(bus.o_res_valid),  32'd1);
      idle();
      chk("t1_valid_drop", 32'(bus.o_res_valid), 32'd0);

      // 0,-1,0,0,0,0,0,+1 -> -63, full length, no flags
      do_reset();
      drive(1, 1, Z, 0); drive(1, 1, N, 0);
      for (int k = 0; k < 5; k++) drive(1, 1, Z, 0);
      drive(1, 1, P, 1);
      chk("t2_data",   32'(bus.o_res_data),   32'h1C1);
      chk("t2_model",  32'(m_data),           32'h1C1);
      chk("t2_digits", 32'(bus.o_res_digits), 32'd8);
      chk("t2_flags",  32'({err_ill, err_trunc, err_ovr}), 32'h0);
      idle();

      // Ten +1 digits: finalize after the 8th, last two dropped
      do_reset();
      for (int k = 0; k < 8; k++) drive(1, 1, P, 0);
      chk("t3_data8",   32'(bus.o_res_data),   32'h0FF);
      chk("t3_digits8", 32'(bus.o_res_digits), 32'd8);
      chk("t3_trunc",   32'(err_trunc),        32'd1);
      drive(1, 1, P, 0); drive(1, 1, P, 1);
      chk("t3_data10",  32'(bus.o_res_data),   32'h0FF);
      chk("t3_valid10", 32'(bus.o_res_valid),  32'd0);
      drive(1, 1, P, 1);
      chk("t3_idle_data",   32'(bus.o_res_data),   32'h080);
      chk("t3_idle_digits", 32'(bus.o_res_digits), 32'd1);
      idle();

      // Single illegal digit
      do_reset();
      drive(1, 1, I, 1);
      chk("t4_data",    32'(bus.o_res_data),   32'h0);
      chk("t4_digits",  32'(bus.o_res_digits), 32'd1);
      chk("t4_illegal", 32'(err_ill),          32'd1);
      idle();

      // Back-to-back results with consumer stalled -> overrun
      do_reset();
      bus.i_res_ready = 1'b0;
      drive(1, 1, P, 1); drive(1, 1, N, 1);
      chk("t5_data",    32'(bus.o_res_data),  32'h180);
      chk("t5_overrun", 32'(err_ovr),         32'd1);
      chk("t5_valid",   32'(bus.o_res_valid), 32'd1);
      bus.i_res_ready = 1'b1;
      idle();
      chk("t5_valid_drop", 32'(bus.o_res_valid), 32'd0);

      // Reset mid-stream drops the partial stream
      do_reset();
      drive(1, 1, P, 0); drive(1, 1, N, 0); drive(1, 1, P, 0);
      rstn = 1'b0;
      idle();
      rstn = 1'b1;
      chk("t6_valid_rst", 32'(bus.o_res_valid), 32'd0);
      drive(1, 1, P, 1);
      chk("t6_data",   32'(bus.o_res_data),   32'h080);
      chk("t6_digits", 32'(bus.o_res_digits), 32'd1);
      idle();

      // Random streams with gaps, random ready and occasional resets
      do_reset();
      for (int s = 0; s < 400; s++) begin
         int len;
         len = $urandom_range(1, MAXD + 3);
         for (int k = 0; k < len; k++) begin
            int gaps;
            gaps = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
               int pat;
               pat = $urandom_range(0, 2);
               bus.i_res_ready = 1'($urandom_range(0, 1));
               drive(pat == 1, pat == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            begin
               int r;
               logic [1:0] d;
               r = $urandom_range(0, 19);
               if (r == 0 && k < MAXD) d = I;
               else if (r % 3 == 0)    d = P;
               else if (r % 3 == 1)    d = N;
               else                    d = Z;
               bus.i_res_ready = 1'($urandom_range(0, 3) != 0);
               drive(1, 1, d, k == len - 1);
            end
         end
         if ($urandom_range(0, 24) == 0) do_reset();
      end
      bus.i_res_ready = 1'b1;
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/msdf_otf_converter.md
MSDF_OTF_CONVERTER -- requirements
Module: msdf_otf_converter

Interface
REQ-001 Parameter DATA_WIDTH, default 2, width of one signed-digit on the write bus.
REQ-002 Parameter MAX_DIGITS, default 8, maximum number of digits per stream.
REQ-003 Parameter OUT_WIDTH, default MAX_DIGITS+1, width of the two's-complement result; fixed at MAX_DIGITS+1.
REQ-004 i_clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 i_rstn  in  1  reset, synchronous, active-low.
REQ-006 i_mbus_wen  in  1  write enable, high active.
REQ-007 i_mbus_wdata  in  DATA_WIDTH  digit: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal.
REQ-008 i_mbus_wvalid  in  1  digit valid.
REQ-009 i_mbus_wlast  in  1  marks the last digit of a stream.
REQ-010 o_res_data  out  OUT_WIDTH  signed result, scaled by 2^(MAX_DIGITS-1).
REQ-011 o_res_valid  out  1  result held and valid.
REQ-012 i_res_ready  in  1  consumer accepts the result.
REQ-013 o_res_digits  out  $clog2(MAX_DIGITS+1)  number of digits that formed o_res_data.
REQ-014 o_err_illegal, o_err_trunc, o_err_overrun  out  1 each  sticky error flags.

Function
REQ-015 A digit SHALL be accepted in a cycle where i_mbus_wen && i_mbus_wvalid; other cycles SHALL leave all state unchanged except the output handshake.
REQ-016 Digit k (k=0 is the first, MSD-first) SHALL carry weight 2^-k, so result range is (-2,2).
REQ-017 Conversion SHALL use on-the-fly Q/QM registers (QM = Q-1): d=+1: Q<={Q,1}, QM<={Q,0}; d=0: Q<={Q,0}, QM<={QM,1}; d=-1: Q<={QM,1}, QM<={QM,0}; no carry-propagate adder on the digit path.
REQ-018 FSM states IDLE, ACCUM, DISCARD; IDLE->ACCUM on a first accepted digit without wlast; ACCUM->IDLE on an accepted digit with wlast; ACCUM->DISCARD when the MAX_DIGITS-th digit is accepted without wlast; DISCARD->IDLE on an accepted digit with wlast.
REQ-019 Finalize happens on the accepted digit with wlast, or on the MAX_DIGITS-th digit; the next cycle SHALL present o_res_data = Q_final << (MAX_DIGITS - count), o_res_digits = count, o_res_valid = 1. Latency 1 cycle.
REQ-020 A single-digit stream (wlast on first digit) SHALL finalize from IDLE directly.
REQ-021 Q/QM and count SHALL clear at each finalize so a new stream may start the very next cycle.
REQ-022 Digits accepted in DISCARD SHALL be dropped; o_err_trunc SHALL set at the truncating finalize.
REQ-023 Illegal digit 2'b11 SHALL be converted as 0 and SHALL set o_err_illegal.
REQ-024 o_res_valid && i_res_ready SHALL clear o_res_valid next cycle unless a finalize occurs the same cycle, in which case the new result loads and o_res_valid stays 1.
REQ-025 A finalize while o_res_valid=1 and i_res_ready=0 SHALL overwrite the result and set o_err_overrun.
REQ-026 Sticky flags SHALL clear only on reset.

Reset
REQ-027 On i_rstn=0 at a clock edge: FSM=IDLE, Q=QM=0, count=0, o_res_data=0, o_res_digits=0, o_res_valid=0, all error flags 0.
REQ-028 Reset mid-stream SHALL discard the partial stream; no result SHALL be produced for it.

Structure
REQ-029 Shared package msdf_pkg SHALL hold the digit encoding constants (SD_POS, SD_NEG, SD_ZERO, SD_ILL) and the FSM state type.
REQ-030 The Q/QM update SHALL be a sub-module msdf_otf_qqm (MAX_DIGITS-wide Q/QM registers, digit in, load/clear controls); shift, FSM and handshake SHALL stay in the top module.

Verification (MAX_DIGITS=8)
REQ-031 Digits +1,0,-1,+1(wlast), ready=1 -> next cycle o_res_data=9'h070 (112), o_res_digits=4, valid for 1 cycle.
REQ-032 Digits 0,-1,0,0,0,0,0,+1(wlast) -> o_res_data=9'h1C1 (-63), o_res_digits=8, no error flags.
REQ-033 Ten +1 digits, wlast on the 10th -> o_res_data=9'h0FF after the 8th digit, o_err_trunc=1, the 9th and 10th digits have no effect, FSM back to IDLE after the 10th.
REQ-034 Single digit 2'b11 with wlast -> o_res_data=0, o_res_digits=1, o_err_illegal=1.
REQ-035 Two streams back-to-back ("+1 wlast", then "-1 wlast") with i_res_ready=0 -> o_res_data=9'h180 (-128), o_err_overrun=1; then ready=1 -> valid drops next cycle.
REQ-036 Reset pulse after 3 digits of a stream, then stream "+1 wlast" -> only result 9'h080, o_res_digits=1.
